// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: FSM state encodings and time-counter command codes,
// used by both this control block and the time counter.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } sw_state_t;

    localparam logic [1:0] CNT_IDLE  = 2'b00;
    localparam logic [1:0] CNT_COUNT = 2'b01;
    localparam logic [1:0] CNT_PAUSE = 2'b10;

    typedef struct packed {
        logic [1:0] cnt_ctrl;
        logic       lap_hold;
        logic       run_led;
    } sw_out_t;

    function automatic sw_out_t decode_state(input sw_state_t s);
        sw_out_t o;
        o = '{cnt_ctrl: CNT_IDLE, lap_hold: 1'b0, run_led: 1'b0};
        case (s)
            ST_COUNT: o = '{cnt_ctrl: CNT_COUNT, lap_hold: 1'b0, run_led: 1'b1};
            ST_PAUSE: o = '{cnt_ctrl: CNT_PAUSE, lap_hold: 1'b0, run_led: 1'b0};
            ST_LAP:   o = '{cnt_ctrl: CNT_COUNT, lap_hold: 1'b1, run_led: 1'b1};
            default:  o = '{cnt_ctrl: CNT_IDLE,  lap_hold: 1'b0, run_led: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low button conditioner: 2-FF synchronizer, stability counter and
// a one-cycle press pulse on each accepted high->low transition.
module btn_debounce #(
    parameter logic [15:0] DEB_CNT = 16'd49
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    logic        sync1;
    logic        sync2;
    logic        level_q;
    logic        press_q;
    logic [15:0] cnt;
    logic [16:0] cnt_inc;

    // Widened increment so the acceptance compare can never see a wrapped count.
    assign cnt_inc = {1'b0, cnt} + 17'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt     <= 16'd0;
        end else begin
            sync1   <= btn_n;
            sync2   <= sync1;
            press_q <= 1'b0;
            if (sync2 == level_q) begin
                cnt <= 16'd0;
            end else if (cnt_inc >= {1'b0, DEB_CNT}) begin
                level_q <= sync2;
                cnt     <= 16'd0;
                press_q <= ~sync2;
            end else begin
                cnt <= cnt_inc[15:0];
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: three debounced buttons drive a Moore FSM that commands
// the time counter and the lap display latch.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter logic [15:0] DEB_CNT = 16'd49
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_n,
    input  logic       btn_clear_n,
    input  logic       btn_lap_n,
    output logic [1:0] cnt_ctrl,
    output logic       lap_hold,
    output logic [1:0] state,
    output logic       run_led
);

    logic      start_p;
    logic      clear_p;
    logic      lap_p;
    sw_state_t state_q;
    sw_state_t state_d;
    sw_out_t   outs;

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_start (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_start_n), .press(start_p)
    );
    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_clear (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_clear_n), .press(clear_p)
    );
    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_lap (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_lap_n), .press(lap_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Each branch tests only the pulses legal in that state, in clear > start > lap order.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_p) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (start_p)    state_d = ST_PAUSE;
                else if (lap_p) state_d = ST_LAP;
            end
            ST_PAUSE: begin
                if (clear_p)      state_d = ST_IDLE;
                else if (start_p) state_d = ST_COUNT;
            end
            ST_LAP: begin
                if (start_p)    state_d = ST_PAUSE;
                else if (lap_p) state_d = ST_COUNT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        outs = decode_state(state_q);
    end

    assign cnt_ctrl = outs.cnt_ctrl;
    assign lap_hold = outs.lap_hold;
    assign run_led  = outs.run_led;
    assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: debounce timing, glitch rejection,
// table of button presses through all FSM transitions, and reset behaviour.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_start_n;
    logic       btn_clear_n;
    logic       btn_lap_n;
    logic [1:0] cnt_ctrl;
    logic       lap_hold;
    logic [1:0] state;
    logic       run_led;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       s;
        logic       c;
        logic       l;
        logic [1:0] st;
        logic [1:0] cc;
        logic       lh;
        logic       led;
    } vec_t;

    vec_t vecs[19];

    stopwatch_ctrl #(.DEB_CNT(16'd49)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .btn_start_n(btn_start_n), .btn_clear_n(btn_clear_n), .btn_lap_n(btn_lap_n),
        .cnt_ctrl(cnt_ctrl), .lap_hold(lap_hold), .state(state), .run_led(run_led)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [1:0] st, input logic [1:0] cc,
                           input logic lh, input logic led);
        chk({name, ".state"},    state,           st);
        chk({name, ".cnt_ctrl"}, cnt_ctrl,        cc);
        chk({name, ".lap_hold"}, {1'b0, lap_hold}, {1'b0, lh});
        chk({name, ".run_led"},  {1'b0, run_led},  {1'b0, led});
    endtask

    task automatic press(input logic s, input logic c, input logic l);
        @(posedge clk); #1;
        btn_start_n = ~s;
        btn_clear_n = ~c;
        btn_lap_n   = ~l;
        repeat (60) @(posedge clk);
        #1;
        btn_start_n = 1'b1;
        btn_clear_n = 1'b1;
        btn_lap_n   = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        //            s     c     l     state  cnt    hold  led
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'b11, 2'b01, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b11, 2'b01, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'b11, 2'b01, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1};

        rst_n       = 1'b0;
        btn_start_n = 1'b1;
        btn_clear_n = 1'b1;
        btn_lap_n   = 1'b1;
        repeat (3) @(negedge clk);
        chk_all("reset", 2'b00, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Start held: pulse at edge 51, state changes on edge 52.
        @(posedge clk); #1;
        btn_start_n = 1'b0;
        for (int k = 1; k <= 51; k++) @(posedge clk);
        #1;
        chk("latency.edge51.state", state, 2'b00);
        @(posedge clk); #1;
        chk_all("latency.edge52", 2'b01, 2'b01, 1'b0, 1'b1);
        repeat (150) @(posedge clk);
        #1;
        btn_start_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("held.single_pulse.state", state, 2'b01);

        do_reset();

        // Short glitch, then a long low broken by a brief release.
        @(posedge clk); #1;
        btn_start_n = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        btn_start_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("glitch20.state", state, 2'b00);
        @(posedge clk); #1;
        btn_start_n = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        btn_start_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        btn_start_n = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        btn_start_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("restart.state", state, 2'b00);

        for (int i = 0; i < 19; i++) begin
            press(vecs[i].s, vecs[i].c, vecs[i].l);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].cc, vecs[i].lh, vecs[i].led);
        end

        // Asynchronous reset while in LAP.
        press(1'b0, 1'b0, 1'b1);
        chk_all("lap_before_rst", 2'b11, 2'b01, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 2'b00, 2'b00, 1'b0, 1'b0);

        // Button already held at reset release gives exactly one press.
        btn_start_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk_all("held_at_rst", 2'b01, 2'b01, 1'b0, 1'b1);
        btn_start_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("held_at_rst.release.state", state, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: DEB_CNT, default 16'd49, number of stable clk cycles required to accept a button level change.
REQ-002 Port: clk  input  1  system clock, 50 MHz.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: btn_start_n  input  1  raw start/stop button, active-low, asynchronous to clk.
REQ-005 Port: btn_clear_n  input  1  raw clear button, active-low, asynchronous to clk.
REQ-006 Port: btn_lap_n  input  1  raw lap/split button, active-low, asynchronous to clk.
REQ-007 Port: cnt_ctrl  output  2  time-counter command: 2'b00 IDLE (clear), 2'b01 COUNT, 2'b10 PAUSE.
REQ-008 Port: lap_hold  output  1  high = display latch frozen, counter keeps running.
REQ-009 Port: state  output  2  current FSM state encoding.
REQ-010 Port: run_led  output  1  high when the counter is advancing.

Function
REQ-011 Each button SHALL pass through a 2-FF synchronizer, then a debouncer accepting a new level only after DEB_CNT consecutive cycles of identical synchronized value.
REQ-012 Any mismatch during debounce SHALL restart the stability count from 0.
REQ-013 Each debouncer SHALL emit a 1-cycle press pulse on an accepted high->low transition and nothing on release.
REQ-014 A raw press held stable SHALL produce its pulse on clk edge 2+DEB_CNT after the first edge sampling it low; the FSM SHALL update on the following edge.
REQ-015 The FSM SHALL be Moore, with states IDLE=2'b00, COUNT=2'b01, PAUSE=2'b10, LAP=2'b11.
REQ-016 IDLE: start -> COUNT; clear and lap ignored.
REQ-017 COUNT: start -> PAUSE; lap -> LAP; clear ignored.
REQ-018 PAUSE: start -> COUNT; clear -> IDLE; lap ignored.
REQ-019 LAP: lap -> COUNT; start -> PAUSE; clear ignored.
REQ-020 Simultaneous pulses SHALL be resolved with priority clear > start > lap; only the highest-priority pulse valid in the current state SHALL act, and the others are discarded.
REQ-021 Outputs SHALL be decoded from registered state only:
- IDLE: cnt_ctrl=00, lap_hold=0, run_led=0.
- COUNT: cnt_ctrl=01, lap_hold=0, run_led=1.
- PAUSE: cnt_ctrl=10, lap_hold=0, run_led=0.
- LAP: cnt_ctrl=01, lap_hold=1, run_led=1.
REQ-022 A button held indefinitely SHALL produce exactly one pulse; a new pulse requires an accepted release first.
REQ-023 The debounce counter SHALL saturate at DEB_CNT and never wrap.

Reset
REQ-024 While rst_n=0, the block SHALL hold state=IDLE, cnt_ctrl=00, lap_hold=0, run_led=0, synchronizers and debounced levels at 1 (released), and debounce counters at 0.
REQ-025 Reset assertion mid-operation SHALL force these values immediately (asynchronously) and discard any pending pulse.
REQ-026 A button already held low at reset release SHALL produce one pulse after debounce.

Structure
REQ-027 State encodings and cnt_ctrl codes SHALL live in the shared stopwatch package, so the time counter and this block use identical constants.
REQ-028 The debouncer SHALL be a sub-module btn_debounce (sync + counter + edge detect, parameter DEB_CNT), instantiated three times.

Verification
REQ-029 DEB_CNT=49, reset, start held low 60 cycles -> one start pulse at edge 51; state 00->01 at edge 52; cnt_ctrl=01; run_led=1.
REQ-030 Start glitch low for 20 cycles, then high -> no pulse; state stays IDLE.
REQ-031 From COUNT: lap -> state=11, cnt_ctrl=01, lap_hold=1; second lap -> state=01, lap_hold=0.
REQ-032 From COUNT: start -> PAUSE (cnt_ctrl=10); clear -> IDLE (cnt_ctrl=00); clear in COUNT ignored.
REQ-033 In PAUSE, clear and start pressed together -> clear wins, state=IDLE; start pulse discarded.
REQ-034 rst_n dropped while in LAP -> same cycle: state=00, lap_hold=0, cnt_ctrl=00.
